// File: rtl/sa_cache_if.sv
// CPU-side request/response and line-granular memory port of the set-associative cache.
// slave: the cache controller's view; master: the requester/memory environment's view.
interface sa_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wvalid;
  logic              mem_wready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_wready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata
  );
endinterface

// File: rtl/sa_cache_controller.sv
// Set-associative write-back/write-allocate cache controller with flop-array storage,
// dirty-line writeback and lowest-invalid / per-set round-robin replacement.
module sa_cache_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 64,
  parameter int WAYS   = 2
) (
  input  logic      clk,
  input  logic      rst,
  sa_cache_if.slave bus,
  output logic      busy
);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WI_W   = $clog2(WORDS);
  localparam int OFF_W  = BYTE_W + WI_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINES  = SETS * WAYS;
  localparam int LINE_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, WB_DATA, REFILL_REQ, REFILL, RESPOND
  } state_e;

  state_e                        state_q, state_d;
  logic                          we_q, we_d;
  logic [TAG_W-1:0]              tag_q, tag_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [WI_W-1:0]               widx_q, widx_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic [WAY_W-1:0]              victim_q, victim_d;
  logic                          use_rr_q, use_rr_d;
  logic [WI_W-1:0]               cnt_q, cnt_d;
  logic [LINES-1:0]              valid_q, valid_d;
  logic [LINES-1:0]              dirty_q, dirty_d;
  logic [SETS-1:0][WAY_W-1:0]    rr_q, rr_d;

  logic [TAG_W-1:0]              tag_arr_q [LINES];
  logic [DATA_W-1:0]             data_q [LINES*WORDS];

  logic                          tag_we;
  logic                          data_we;
  logic [LINE_W+WI_W-1:0]        data_waddr;
  logic [DATA_W-1:0]             data_wdata;

  logic                          hit, inv_found;
  logic [WAY_W-1:0]              hit_way, inv_way, vic_sel;
  logic [LINE_W-1:0]             hit_line, vic_line, sel_line;
  logic                          unused_addr_bits;

  function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx,
                                                input logic [WAY_W-1:0] way);
    return LINE_W'(int'(idx) * WAYS + int'(way));
  endfunction

  always_comb unused_addr_bits = ^bus.req_addr[BYTE_W-1:0];

  // Tag match across the set, plus the lowest-index invalid way for replacement.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[line_of(idx_q, WAY_W'(w))] &&
          tag_arr_q[line_of(idx_q, WAY_W'(w))] == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[line_of(idx_q, WAY_W'(w))]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    vic_sel  = inv_found ? inv_way : rr_q[idx_q];
    hit_line = line_of(idx_q, hit_way);
    vic_line = line_of(idx_q, victim_q);
    sel_line = line_of(idx_q, vic_sel);
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    victim_d   = victim_q;
    use_rr_d   = use_rr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    rr_d       = rr_q;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_waddr = {vic_line, widx_q};
    data_wdata = wdata_q;

    bus.req_ready     = (state_q == IDLE);
    bus.resp_valid    = 1'b0;
    bus.resp_rdata    = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_wvalid    = 1'b0;
    bus.mem_wdata     = '0;
    busy              = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          tag_d   = bus.req_addr[ADDR_W-1 -: TAG_W];
          idx_d   = bus.req_addr[OFF_W +: IDX_W];
          widx_d  = bus.req_addr[BYTE_W +: WI_W];
          wdata_d = bus.req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          bus.resp_valid = 1'b1;
          if (we_q) begin
            data_we           = 1'b1;
            data_waddr        = {hit_line, widx_q};
            dirty_d[hit_line] = 1'b1;
          end else begin
            bus.resp_rdata = data_q[{hit_line, widx_q}];
          end
          state_d = IDLE;
        end else begin
          victim_d = vic_sel;
          use_rr_d = !inv_found;
          cnt_d    = '0;
          state_d  = (valid_q[sel_line] && dirty_q[sel_line]) ? WRITEBACK : REFILL_REQ;
        end
      end
      WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {tag_arr_q[vic_line], idx_q, {OFF_W{1'b0}}};
        if (bus.mem_req_ready) state_d = WB_DATA;
      end
      WB_DATA: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = data_q[{vic_line, cnt_q}];
        if (bus.mem_wready) begin
          if (cnt_q == WI_W'(WORDS - 1)) begin
            valid_d[vic_line] = 1'b0;
            cnt_d             = '0;
            state_d           = REFILL_REQ;
          end else begin
            cnt_d = cnt_q + WI_W'(1);
          end
        end
      end
      REFILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (bus.mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (bus.mem_rvalid) begin
          data_we    = 1'b1;
          data_waddr = {vic_line, cnt_q};
          data_wdata = bus.mem_rdata;
          if (cnt_q == WI_W'(WORDS - 1)) begin
            // The line only becomes valid once every beat has landed.
            valid_d[vic_line] = 1'b1;
            dirty_d[vic_line] = 1'b0;
            tag_we            = 1'b1;
            if (use_rr_q && WAYS > 1) rr_d[idx_q] = rr_q[idx_q] + WAY_W'(1);
            cnt_d   = '0;
            state_d = RESPOND;
          end else begin
            cnt_d = cnt_q + WI_W'(1);
          end
        end
      end
      RESPOND: begin
        bus.resp_valid = 1'b1;
        if (we_q) begin
          data_we           = 1'b1;
          dirty_d[vic_line] = 1'b1;
        end else begin
          bus.resp_rdata = data_q[{vic_line, widx_q}];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      tag_q    <= '0;
      idx_q    <= '0;
      widx_q   <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      use_rr_q <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      use_rr_q <= use_rr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      rr_q     <= rr_d;
    end
  end

  // Tag and data storage are qualified by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (tag_we)  tag_arr_q[vic_line] <= tag_q;
    if (data_we) data_q[data_waddr]  <= data_wdata;
  end
endmodule

// File: tb/tb_sa_cache_controller.sv
// Randomized bench for sa_cache_controller: a flat golden memory gives expected data,
// a per-set tag/valid/dirty/pointer model gives expected hits, victims and traffic.
module tb_sa_cache_controller;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int SETS   = 64;
  localparam int WAYS   = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  sa_cache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sa_cache_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          force_stall = -1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory model: backing store and the architecturally visible (golden) value per word.
  logic [31:0] backing [int unsigned];
  logic [31:0] golden  [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] rd_backing(input int unsigned wa);
    return backing.exists(wa) ? backing[wa] : init_word(wa);
  endfunction
  function automatic logic [31:0] rd_golden(input int unsigned wa);
    return golden.exists(wa) ? golden[wa] : init_word(wa);
  endfunction

  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int unsigned m_rr    [SETS];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
      end
    end
    golden = backing;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, bus.req_ready, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_resp_valid"}, bus.resp_valid, 0);
    check_eq({tag, "_resp_rdata"}, bus.resp_rdata, 0);
    check_eq({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    check_eq({tag, "_mem_req_addr"}, bus.mem_req_addr, 0);
    check_eq({tag, "_mem_wvalid"}, bus.mem_wvalid, 0);
  endtask

  task automatic stall_len(output int n);
    n = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
  endtask

  task automatic mem_handshake(input logic exp_we, input logic [31:0] exp_addr);
    int n;
    stall_len(n);
    for (int s = 0; s < n; s++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rvalid    = 1'($urandom_range(0, 1));
      bus.mem_rdata     = $urandom;
      check_eq("mreq_valid_hold", bus.mem_req_valid, 1);
      check_eq("mreq_we_hold", bus.mem_req_we, exp_we);
      check_eq("mreq_addr_hold", bus.mem_req_addr, exp_addr);
      @(negedge clk);
    end
    bus.mem_rvalid    = 1'b0;
    bus.mem_req_ready = 1'b1;
    check_eq("mreq_valid", bus.mem_req_valid, 1);
    check_eq("mreq_we", bus.mem_req_we, exp_we);
    check_eq("mreq_addr", bus.mem_req_addr, exp_addr);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
  endtask

  // One complete CPU transaction; abort_at >= 0 asserts reset after that many refill beats.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int abort_at);
    int unsigned set, tag, wa, vic, line_wa;
    int          hw, n;
    bit          hit, use_rr;
    logic [31:0] wb_addr, exp;
    set = (addr >> 4) % SETS;
    tag = addr >> 10;
    wa  = addr >> 2;
    hit = 1'b0;
    hw  = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) begin hit = 1'b1; hw = w; end

    check_eq("idle_req_ready", bus.req_ready, 1);
    check_eq("idle_busy", busy, 0);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    check_eq("lookup_req_ready", bus.req_ready, 0);
    check_eq("lookup_busy", busy, 1);

    if (hit) begin
      exp = we ? 32'h0 : rd_golden(wa);
      check_eq("hit_resp_valid", bus.resp_valid, 1);
      check_eq("hit_resp_rdata", bus.resp_rdata, exp);
      check_eq("hit_no_mem", bus.mem_req_valid, 0);
      if (we) begin
        golden[wa]       = wdata;
        m_dirty[set][hw] = 1'b1;
      end
      @(negedge clk);
    end else begin
      check_eq("miss_resp_valid", bus.resp_valid, 0);
      vic    = m_rr[set];
      use_rr = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[set][w]) begin vic = w; use_rr = 1'b0; end
      @(negedge clk);
      if (m_valid[set][vic] && m_dirty[set][vic]) begin
        wb_addr = (m_tag[set][vic] << 10) | (set << 4);
        mem_handshake(1'b1, wb_addr);
        line_wa = wb_addr >> 2;
        for (int i = 0; i < WORDS; i++) begin
          exp = rd_golden(line_wa + i);
          stall_len(n);
          for (int s = 0; s < n; s++) begin
            bus.mem_wready = 1'b0;
            check_eq("wb_wvalid_hold", bus.mem_wvalid, 1);
            check_eq("wb_wdata_hold", bus.mem_wdata, exp);
            @(negedge clk);
          end
          bus.mem_wready = 1'b1;
          check_eq("wb_wvalid", bus.mem_wvalid, 1);
          check_eq("wb_wdata", bus.mem_wdata, exp);
          backing[line_wa + i] = exp;
          @(negedge clk);
          bus.mem_wready = 1'b0;
        end
        m_valid[set][vic] = 1'b0;
      end
      mem_handshake(1'b0, addr & ~32'hF);
      line_wa = (addr & ~32'hF) >> 2;
      for (int i = 0; i < WORDS; i++) begin
        if (i == abort_at) begin
          bus.mem_rvalid = 1'b0;
          rst = 1'b1;
          #1;
          check_reset_outputs("abort");
          @(negedge clk);
          rst = 1'b0;
          model_reset();
          return;
        end
        n = $urandom_range(0, 2);
        for (int s = 0; s < n; s++) begin
          bus.mem_rvalid = 1'b0;
          check_eq("refill_no_resp", bus.resp_valid, 0);
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd_backing(line_wa + i);
        @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
      exp = we ? 32'h0 : rd_golden(wa);
      check_eq("fill_resp_valid", bus.resp_valid, 1);
      check_eq("fill_resp_rdata", bus.resp_rdata, exp);
      m_valid[set][vic] = 1'b1;
      m_tag[set][vic]   = tag;
      m_dirty[set][vic] = we;
      if (use_rr) m_rr[set] = (m_rr[set] + 1) % WAYS;
      if (we) golden[wa] = wdata;
      @(negedge clk);
    end
    check_eq("done_busy", busy, 0);
    check_eq("done_resp_valid", bus.resp_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst               = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_wready    = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 32'h0000_0100, 32'h0, -1);
    do_req(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, -1);
    do_req(1'b0, 32'h0000_0104, 32'h0, -1);
    do_req(1'b0, 32'h0000_010C, 32'h0, -1);

    do_req(1'b1, 32'h0000_0000, 32'h1111_0000, -1);
    do_req(1'b1, 32'h0000_0400, 32'h2222_0400, -1);
    do_req(1'b0, 32'h0000_0800, 32'h0, -1);
    do_req(1'b0, 32'h0000_0C00, 32'h0, -1);

    force_stall = 5;
    do_req(1'b1, 32'h0000_0010, 32'hAAAA_0010, -1);
    do_req(1'b1, 32'h0000_041C, 32'hBBBB_041C, -1);
    do_req(1'b0, 32'h0000_0814, 32'h0, -1);
    force_stall = -1;

    do_req(1'b0, 32'h0000_2020, 32'h0, 2);
    @(negedge clk);
    do_req(1'b0, 32'h0000_2020, 32'h0, -1);

    do_req(1'b0, 32'h0000_1000, 32'h0, -1);
    do_req(1'b0, 32'h0000_1400, 32'h0, -1);
    do_req(1'b0, 32'h0000_1808, 32'h0, -1);

    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      do_req(1'($urandom_range(0, 1)), a, $urandom, -1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
